// File: rtl/slow_clock_monitor_if.sv
// slow_clock_monitor_if
// Purpose: groups the slow-wave input and the monitor's results so one
//          bundle connects the monitor to its consumers.
// Signals:
//   slow_in      - asynchronous slow square wave (into the monitor)
//   tick         - one-cycle strobe per detected rising edge of slow_in
//   level        - synchronized level of slow_in
//   period       - system cycles between the last two detected rising edges
//   period_valid - period holds a real measurement
//   stopped      - no edge since reset, or the timeout expired
// Handshake: there is no valid/ready pair and no backpressure. tick is a
//   strobe that is true for exactly one clock per edge and must be consumed
//   in that cycle; period is meaningful only while period_valid is high.
interface slow_clock_monitor_if #(
   parameter int CNT_WIDTH = 26
);
   logic                 slow_in;
   logic                 tick;
   logic                 level;
   logic [CNT_WIDTH-1:0] period;
   logic                 period_valid;
   logic                 stopped;

   // master drives the wave and watches the results; slave is the monitor.
   modport master (
      output slow_in,
      input  tick, level, period, period_valid, stopped
   );

   modport slave (
      input  slow_in,
      output tick, level, period, period_valid, stopped
   );
endinterface

// File: rtl/slow_clock_monitor.sv
// slow_clock_monitor
// Purpose: brings an asynchronous slow square wave into the system clock
//          domain, emits one tick per rising edge, measures the edge-to-edge
//          period in system cycles and flags a stopped source.
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-high; clears all state
//   mon       - slave side of slow_clock_monitor_if (slow_in in, results out)
//   dbg_state - current FSM state (0 IDLE, 1 ARMED, 2 RUNNING)
module slow_clock_monitor #(
   parameter int CNT_WIDTH = 26,
   parameter int TIMEOUT   = 50_000_000
) (
   input  logic                 clock,
   input  logic                 reset,
   slow_clock_monitor_if.slave  mon,
   output logic [1:0]           dbg_state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      RUNNING = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] ONE_CNT     = CNT_WIDTH'(1);

   state_t               state_q, state_d;
   logic                 s1, s2, s3;
   logic                 detect;
   logic                 timeout;
   logic                 tick_q;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0] period_q, period_d;

   // Two-flop synchronizer plus a history flop for edge detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         s1     <= mon.slow_in;
         s2     <= s1;
         s3     <= s2;
         tick_q <= detect;
      end
   end

   assign detect = s2 & ~s3;

   // A detect in the same cycle as the count reaching TIMEOUT is a normal
   // edge; the timeout only fires when no edge arrives.
   assign timeout = (state_q != IDLE) && (cnt_q == TIMEOUT_CNT) && !detect;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      case (state_q)
         IDLE: begin
            // First edge after idle only starts timing; no period yet.
            if (detect) begin
               state_d = ARMED;
               cnt_d   = ONE_CNT;
            end else begin
               cnt_d   = '0;
            end
         end
         ARMED, RUNNING: begin
            if (detect) begin
               state_d  = RUNNING;
               period_d = cnt_q;
               cnt_d    = ONE_CNT;
            end else if (timeout) begin
               // period keeps its last value; period_valid drops with IDLE.
               state_d  = IDLE;
               cnt_d    = '0;
            end else begin
               cnt_d    = cnt_q + ONE_CNT;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // stopped/period_valid are pure state decodes, so an asynchronous reset
   // takes them to their idle values at once.
   assign mon.tick         = tick_q;
   assign mon.level        = s2;
   assign mon.period       = period_q;
   assign mon.period_valid = (state_q == RUNNING);
   assign mon.stopped      = (state_q == IDLE);
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_slow_clock_monitor.sv
module tb_slow_clock_monitor;

   localparam int CW = 8;
   localparam int TO = 100;
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_RUNNING = 2'd2;

   typedef struct {
      int          gap;         // cycles from previous rise to this rise
      int          hi;          // cycles the previous pulse stays high
      logic [CW-1:0] exp_period;
      logic        exp_valid;
      logic        exp_stopped;
      logic [1:0]  exp_state;
      logic        exp_seen;    // stopped seen high since previous tick
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset;
   int   cyc = 0;
   logic [1:0] dbg_state;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   slow_clock_monitor_if #(.CNT_WIDTH(CW)) mon_if ();

   slow_clock_monitor #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
      .clock     (clock),
      .reset     (reset),
      .mon       (mon_if.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   int   errors = 0;
   int   checks = 0;
   vec_t pend;
   bit   pend_on = 1'b0;
   bit   stop_seen = 1'b0;
   vec_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle checks, sampled on the falling edge. c counts cycles since
   // the most recent rise of slow_in.
   task automatic cycle_checks(input int c);
      logic [31:0] e;
      if (mon_if.tick === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_tick", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            check("tick_cycle", 32'(cyc), e);
         end
      end
      if (pend_on) begin
         if (c == 1) check("level_before_sync", 32'(mon_if.level), 32'd0);
         if (c == 2) check("level_after_sync", 32'(mon_if.level), 32'd1);
         if (c == 3) begin
            check("period", 32'(mon_if.period), 32'(pend.exp_period));
            check("period_valid", 32'(mon_if.period_valid), 32'(pend.exp_valid));
            check("stopped", 32'(mon_if.stopped), 32'(pend.exp_stopped));
            check("state", 32'(dbg_state), 32'(pend.exp_state));
            check("stop_seen", 32'(stop_seen), 32'(pend.exp_seen));
            pend_on   = 1'b0;
            stop_seen = 1'b0;
         end
      end
      if (mon_if.stopped === 1'b1) stop_seen = 1'b1;
   endtask

   // ---------------- driver ----------------
   // One window: lower the running pulse after v.hi cycles, rise again at
   // v.gap and queue the expected tick three cycles later.
   task automatic apply(input vec_t v, input bit do_rise);
      for (int c = 1; c <= v.gap; c++) begin
         @(negedge clock);
         cycle_checks(c);
         if (c == v.hi) mon_if.slow_in = 1'b0;
         if (do_rise && c == v.gap) begin
            mon_if.slow_in = 1'b1;
            exp_q.push_back(32'(cyc + 3));
            pend    = v;
            pend_on = 1'b1;
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tick"}, 32'(mon_if.tick), 32'd0);
      check({tag, "_level"}, 32'(mon_if.level), 32'd0);
      check({tag, "_period"}, 32'(mon_if.period), 32'd0);
      check({tag, "_valid"}, 32'(mon_if.period_valid), 32'd0);
      check({tag, "_stopped"}, 32'(mon_if.stopped), 32'd1);
      check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
   endtask

   initial begin
      vec_t v;
      reset          = 1'b1;
      mon_if.slow_in = 1'b0;

      // Rise timing table: gap, pulse width, then expectations after the tick.
      tbl[0] = '{10,  5, 8'd0,   1'b0, 1'b0, ST_ARMED,   1'b1};
      tbl[1] = '{40, 20, 8'd40,  1'b1, 1'b0, ST_RUNNING, 1'b0};
      tbl[2] = '{40, 20, 8'd40,  1'b1, 1'b0, ST_RUNNING, 1'b0};
      tbl[3] = '{37, 10, 8'd37,  1'b1, 1'b0, ST_RUNNING, 1'b0};
      tbl[4] = '{3,   1, 8'd3,   1'b1, 1'b0, ST_RUNNING, 1'b0};
      tbl[5] = '{100, 50, 8'd100, 1'b1, 1'b0, ST_RUNNING, 1'b0};
      tbl[6] = '{101, 50, 8'd100, 1'b0, 1'b0, ST_ARMED,   1'b1};
      tbl[7] = '{55, 20, 8'd55,  1'b1, 1'b0, ST_RUNNING, 1'b0};
      tbl[8] = '{40, 20, 8'd40,  1'b1, 1'b0, ST_RUNNING, 1'b0};

      // Reset behaviour with slow_in low.
      repeat (3) @(negedge clock);
      check_reset_values("in_reset");
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check_reset_values("after_reset");

      // Single rise, square wave, edge cases at and past the timeout.
      for (int i = 0; i < 9; i++) apply(tbl[i], 1'b1);

      // Stop: wave held low after the last tick.
      for (int c = 1; c <= 105; c++) begin
         @(negedge clock);
         cycle_checks(c);
         if (c == 20) mon_if.slow_in = 1'b0;
         if (c == 102) begin
            check("stop_not_yet", 32'(mon_if.stopped), 32'd1 - 32'd1);
            check("valid_not_yet", 32'(mon_if.period_valid), 32'd1);
         end
         if (c == 103) begin
            check("stop_stopped", 32'(mon_if.stopped), 32'd1);
            check("stop_valid", 32'(mon_if.period_valid), 32'd0);
            check("stop_period_kept", 32'(mon_if.period), 32'd40);
            check("stop_state", 32'(dbg_state), 32'(ST_IDLE));
         end
      end

      // Re-arm from idle, then reset in the middle of a measurement.
      v = '{5, 1, 8'd40, 1'b0, 1'b0, ST_ARMED, 1'b1};
      apply(v, 1'b1);
      v = '{40, 20, 8'd40, 1'b1, 1'b0, ST_RUNNING, 1'b0};
      apply(v, 1'b1);
      v = '{30, 20, 8'd30, 1'b1, 1'b0, ST_RUNNING, 1'b0};
      apply(v, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clock);
         cycle_checks(c);
      end
      #2;
      reset          = 1'b1;
      mon_if.slow_in = 1'b0;
      #1;
      check_reset_values("mid_reset");
      exp_q.delete();
      pend_on   = 1'b0;
      stop_seen = 1'b0;
      @(negedge clock);
      reset = 1'b0;

      // First tick after reset must not update period.
      v = '{8, 1, 8'd0, 1'b0, 1'b0, ST_ARMED, 1'b1};
      apply(v, 1'b1);
      v = '{40, 20, 8'd40, 1'b1, 1'b0, ST_RUNNING, 1'b0};
      apply(v, 1'b1);
      v = '{6, 20, 8'd0, 1'b0, 1'b0, ST_IDLE, 1'b0};
      apply(v, 1'b0);

      check("ticks_outstanding", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/slow_clock_monitor.md
# slow_clock_monitor

Receiving end of the gated slow-clock path: samples an asynchronous slow square wave (e.g. the on/off-gated 5 Hz blink/step output) in the fast system clock domain. It synchronizes the wave and emits a one-cycle tick per rising edge. It measures the period in system cycles and flags when the wave has stopped, for example when switched off. Downstream display-blink and auto-step logic consume `tick` and `stopped` instead of clocking flops from the slow signal.

## Interface
- `CNT_WIDTH`, default 26: width of the period counter and `period` output.
- `TIMEOUT`, default 50_000_000: cycles without a rising edge before `stopped` asserts. Must satisfy 2 ≤ TIMEOUT < 2^CNT_WIDTH.

- `clock` input 1: system clock, rising-edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `slow_in` input 1: asynchronous slow square wave; no phase relation to `clock`.
- `tick` output 1: one-cycle pulse per detected rising edge of `slow_in`.
- `level` output 1: synchronized level of `slow_in`.
- `period` output CNT_WIDTH: cycles between the last two detected rising edges.
- `period_valid` output 1: `period` holds a real measurement.
- `stopped` output 1: no edge seen since reset, or timeout expired.

## Operation
- Synchronizer: two flops `s1`, `s2`, then history flop `s3`. Detect is `s2 & ~s3`. `level` = `s2`.
- `tick` is registered from detect.
- Counter `cnt`:
  - On detect: `cnt` <= 1.
  - Else, in ARMED/RUNNING: `cnt` <= `cnt` + 1.
  - Held at 0 in IDLE.
  - Never wraps, because timeout fires first.
- States:
  - IDLE: `stopped`=1, `period_valid`=0. Detect → ARMED, `stopped` <= 0, `cnt` <= 1.
  - ARMED: detect → RUNNING, `period` <= `cnt`, `period_valid` <= 1. Timeout → IDLE.
  - RUNNING: detect → `period` <= `cnt`, stay in RUNNING. Timeout → IDLE.
- Timeout condition: `cnt` == TIMEOUT and no detect in that cycle. On timeout:
  - `stopped` <= 1, `period_valid` <= 0, `cnt` <= 0.
  - `period` keeps its last value but is qualified invalid.
- Simultaneous detect and timeout in the same cycle: detect wins. It is treated as a normal edge, with `period` = TIMEOUT.
- Falling edges only affect `level`.
- A constant `slow_in`, high or low, from reset yields no ticks and `stopped` stays 1.
- A switched-off source (output held low) ends in `stopped`=1 TIMEOUT cycles after its last rising edge.

## Timing
- Reset values: `tick`=0, `level`=0, `period`=0, `period_valid`=0, `stopped`=1, state=IDLE, `cnt`=0, `s1`/`s2`/`s3`=0.
- Reset may assert mid-measurement. All outputs return to their reset values immediately, without waiting for a clock edge.
- Latency, with `slow_in` rising and setup-safe before clock edge E0:
  - `s1`=1 after E0; detect is true after E1; `tick`=1 after E2, for exactly one cycle.
  - `level`=1 after E1.
- The `period`, `period_valid` and `stopped` updates caused by a detect become visible after the same edge as `tick`.
- Rising edges D cycles apart at `slow_in` (D ≥ 3) give `period` = D.
- Pulses narrower than one clock period may be missed. This is not an error.
- Timeout: with the last detect at edge Ek, `stopped` rises after edge Ek+TIMEOUT if no further detect occurs.

## Test plan
All scenarios use TIMEOUT=100 and CNT_WIDTH=8.
- Reset behaviour: hold `slow_in`=0 and pulse `reset` → `stopped`=1, `period_valid`=0, `tick`=0, `period`=0.
- Single rise: raise `slow_in` once after reset → exactly one `tick`, 3 clocks after the rise. `stopped` falls with it and `period_valid` stays 0.
- Square wave: period 40 cycles, 50% duty → one tick every 40 cycles. After the second tick, `period`=40 and `period_valid`=1; `stopped` stays 0.
- Stop: stop the wave low after a tick → `stopped`=1 and `period_valid`=0 exactly 100 cycles after that tick. `period` still reads 40.
- Boundary: rising edges exactly 100 cycles apart → no timeout, and `period`=100. At 101 cycles apart → `stopped` pulses high, then the next edge re-arms the monitor (ARMED, `period_valid`=0).
- Reset mid-run: assert `reset` between clock edges while RUNNING → outputs go to reset values immediately. After release, the first new tick does not produce a `period` update.
